// File: rtl/cpu_pkg.sv
// Shared datapath types and constants for the 8-bit mini CPU.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t DATA_RESET = '0;

endpackage : cpu_pkg

// File: rtl/reg_bit_cell.sv
// One-bit storage cell: load enable, async active-low clear to RESET_VALUE.
module reg_bit_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next state: take d_i when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    // State flop; clear is asynchronous and overrides any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : reg_bit_cell

// File: rtl/reg_8bit.sv
// General-purpose storage register built from reg_bit_cell instances.
// Optional macro REG_8BIT_PARITY_EN adds a registered even-parity output P.
module reg_8bit
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DATA_RESET)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q
`ifdef REG_8BIT_PARITY_EN
    ,
    output logic             P
`endif
);

    // One enable flop per data bit; all bits share En so loads are all-or-nothing.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        reg_bit_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clk   (CLK),
            .rst_n (CLR),
            .en_i  (En),
            .d_i   (D[i]),
            .q_o   (Q[i])
        );
    end

`ifdef REG_8BIT_PARITY_EN
    logic parity_d_c;

    // Parity of the word being loaded, so P tracks Q with no extra cycle.
    always_comb begin
        parity_d_c = ^D;
    end

    reg_bit_cell #(
        .RESET_VALUE (1'b0)
    ) u_parity (
        .clk   (CLK),
        .rst_n (CLR),
        .en_i  (En),
        .d_i   (parity_d_c),
        .q_o   (P)
    );
`endif

endmodule : reg_8bit

// File: tb/tb_reg_8bit.sv
// Directed self-checking bench for reg_8bit.
module tb_reg_8bit;

    logic       CLK;
    logic       CLR;
    logic [7:0] D;
    logic [2:0] en_src;
    logic [7:0] Q;
`ifdef REG_8BIT_PARITY_EN
    logic       P;
`endif

    int n_cmp;
    int n_err;

    reg_8bit dut (
        .CLK (CLK),
        .CLR (CLR),
        .D   (D),
        .En  (en_src[0]),
        .Q   (Q)
`ifdef REG_8BIT_PARITY_EN
        ,
        .P   (P)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        CLR    = 1'b0;
        D      = 8'h0A;
        en_src = 3'd1;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_err++;
            $display("FAIL reset_initial: Q=%h expected 00", Q);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if (Q !== 8'h00) begin
                n_err++;
                $display("FAIL reset_edge%0d: Q=%h expected 00", i, Q);
            end
`ifdef REG_8BIT_PARITY_EN
            n_cmp++;
            if (P !== 1'b0) begin
                n_err++;
                $display("FAIL reset_parity%0d: P=%b expected 0", i, P);
            end
`endif
        end
    endtask

    task automatic test_load();
        @(negedge CLK);
        CLR    = 1'b1;
        D      = 8'h01;
        en_src = 3'd1;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_err++;
            $display("FAIL load_before_edge: Q=%h expected 00", Q);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 8'h01) begin
            n_err++;
            $display("FAIL load_after_edge: Q=%h expected 01", Q);
        end
    endtask

    task automatic test_hold();
        @(negedge CLK);
        en_src = 3'd0;
        D      = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if (Q !== 8'h01) begin
                n_err++;
                $display("FAIL hold_edge%0d: Q=%h expected 01", i, Q);
            end
        end
    endtask

    task automatic test_clear_mid_cycle();
        @(negedge CLK);
        en_src = 3'd1;
        D      = 8'hA5;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 8'hA5) begin
            n_err++;
            $display("FAIL clear_preload: Q=%h expected a5", Q);
        end
        // Assert clear between edges; no clock is needed for Q to drop.
        #2;
        CLR = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_err++;
            $display("FAIL clear_async: Q=%h expected 00", Q);
        end
        D      = 8'h3C;
        en_src = 3'd1;
        // Release lands on this edge (inside the removal window): no load here.
        @(posedge CLK);
        #1;
        CLR = 1'b1;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_err++;
            $display("FAIL clear_release_edge: Q=%h expected 00", Q);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 8'h3C) begin
            n_err++;
            $display("FAIL clear_release_next: Q=%h expected 3c", Q);
        end
    endtask

    task automatic test_wide_enable();
        @(negedge CLK);
        en_src = 3'b010;
        D      = 8'h0A;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 8'h3C) begin
            n_err++;
            $display("FAIL en_wide_010: Q=%h expected 3c", Q);
        end
        @(negedge CLK);
        en_src = 3'b111;
        D      = 8'h01;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 8'h01) begin
            n_err++;
            $display("FAIL en_wide_111: Q=%h expected 01", Q);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [3];
        vec[0] = 8'h11;
        vec[1] = 8'h22;
        vec[2] = 8'hC3;
        en_src = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            D = vec[i];
            @(posedge CLK);
            #1;
            n_cmp++;
            if (Q !== vec[i]) begin
                n_err++;
                $display("FAIL b2b_%0d: Q=%h expected %h", i, Q, vec[i]);
            end
        end
        // D changes mid-cycle with En high must not reach Q before the edge.
        #1;
        D = 8'h5A;
        #2;
        n_cmp++;
        if (Q !== 8'hC3) begin
            n_err++;
            $display("FAIL no_comb_path: Q=%h expected c3", Q);
        end
    endtask

`ifdef REG_8BIT_PARITY_EN
    task automatic test_parity();
        en_src = 3'd1;
        @(negedge CLK);
        D = 8'h07;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (P !== 1'b1) begin
            n_err++;
            $display("FAIL parity_07: P=%b expected 1", P);
        end
        @(negedge CLK);
        D = 8'h03;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (P !== 1'b0) begin
            n_err++;
            $display("FAIL parity_03: P=%b expected 0", P);
        end
        @(negedge CLK);
        D = 8'h07;
        @(posedge CLK);
        #2;
        CLR = 1'b0;
        #1;
        n_cmp++;
        if (P !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clear: P=%b expected 0", P);
        end
        @(negedge CLK);
        CLR = 1'b1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load();
        test_hold();
        test_clear_mid_cycle();
        test_wide_enable();
        test_back_to_back();
`ifdef REG_8BIT_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_8bit
